ex_branch_rs: RTL and testbench
===============================

# ex_branch_rs

Parametrised branch/jump execution unit with an in-order reservation queue of DEPTH entries. It sits between the allocator and the common data bus (CDB), and feeds IF. Each entry waits for its two source tags to be resolved by CDB broadcasts. The head entry is resolved to a target address, compared with the predicted next PC (raising a redirect on mismatch), and JAL/JALR link values are returned to the CDB arbiter.

## Interface
Parameters:
- XLEN, 32, data and address width
- DEPTH, 4, queue entries; power of two, at least 2
- TAG_W, 4, register tag width; tag value 0 means UNLOCKED (operand valid)

Ports:
- clk  in  1  clock; all state updates on posedge
- rst  in  1  reset, asynchronous, active-high
- rdy  in  1  global enable; when low, all state and outputs hold
- flush  in  1  discard all queued entries
- alloc_en  in  1  enqueue request
- alloc_op  in  3  operation: 0 BEQ, 1 BNE, 2 BLT, 3 BGE, 4 BLTU, 5 BGEU, 6 JAL, 7 JALR
- alloc_pc  in  XLEN  instruction PC
- alloc_offset  in  XLEN  sign-extended immediate
- alloc_pred  in  XLEN  predicted next PC from IF
- alloc_tagx, alloc_tagy  in  TAG_W  source tags
- alloc_datax, alloc_datay  in  XLEN  source values, valid when the matching tag is 0
- alloc_rd_tag  in  TAG_W  destination tag for the link value; 0 means no write
- cdb_en  in  1  CDB broadcast valid
- cdb_tag  in  TAG_W  broadcast tag
- cdb_data  in  XLEN  broadcast value
- full  out  1  count == DEPTH (combinational from registered count)
- count  out  $clog2(DEPTH)+1  occupied entries
- out_en  out  1  one-cycle pulse: a branch was resolved
- out_dest  out  XLEN  resolved next PC
- out_mispredict  out  1  out_dest != entry's pred; valid with out_en
- out_link_en  out  1  link write valid (JAL/JALR with rd_tag != 0)
- out_link_tag  out  TAG_W  link destination tag
- out_link_data  out  XLEN  pc + 4

## Operation
- Storage is a circular queue with head/tail pointers of log2(DEPTH) bits that wrap naturally modulo DEPTH, plus a count register.
- **Enqueue:** when alloc_en && !full, the entry is written at tail, then tail++ and count++.
  - alloc_en while full is ignored; no state changes and no error is raised.
  - full is evaluated from the pre-edge count, so a simultaneous issue does not admit an enqueue.
- **Wakeup:** every cycle with cdb_en, each valid entry whose tagx (or tagy) == cdb_tag and whose tag != 0 takes data := cdb_data and tag := 0.
  - An entry being enqueued in the same cycle also compares its alloc tags against the CDB (bypass).
  - cdb_tag == 0 never matches.
- **Issue:** only the head entry may issue. It issues when count != 0 and both of its tags are 0, at which point head++ and count--.
  - Enqueue and issue in the same cycle leave count unchanged.
- **Resolution (registered on the issue edge):**
  - jump = pc + offset; remain = pc + 4, both modulo 2^XLEN.
  - BEQ/BNE/BLTU/BGEU compare x and y as unsigned; BLT/BGE compare them signed. The branch takes jump if the condition holds, otherwise remain.
  - JAL: dest = jump. JALR: dest = (x + offset) & ~1. Both set link_en = (rd_tag != 0) and link_data = remain.
  - Conditional branches force link_en = 0.
  - mispredict = (dest != pred).
- **Flush:**
  - At the edge, head = tail = count = 0 and out_en, out_link_en and out_mispredict = 0.
  - Flush has priority over enqueue, wakeup and issue.
- **rdy low:** all registers, including the outputs, hold.
- **Idle cycle** (no issue, rdy high): out_en, out_link_en and out_mispredict = 0. out_dest, out_link_tag and out_link_data = 0.

## Timing
- **Reset** (async, immediate): head, tail and count = 0, all entry valid/tag state cleared, every output = 0 and full = 0.
- **Latency:**
  - An entry enqueued with both tags 0 at edge A issues at edge A+1, so out_en is high in the cycle after A+1.
  - An entry woken by the CDB at edge W issues at W+1 if it is head.
  - Throughput is 1 resolution per cycle.
- **Ordering:** a non-head ready entry waits behind an unready head. Outputs therefore appear in program order.
- **Flush with a pending issue:** flush asserted on the same edge as a would-be issue suppresses that output.

## Test plan
- **Reset/idle:** assert rst mid-cycle -> all outputs 0 immediately; count=0, full=0.
- **Taken BEQ:** enqueue BEQ with pc=0x100, offset=0x20, x=y=5, tags 0, pred=0x104 -> the next edge issues; out_en=1, out_dest=0x120, out_mispredict=1, out_link_en=0.
- **JALR with link:**
  - Enqueue JALR with pc=0x200, x=0x1001, offset=4, rd_tag=3, pred=0x1004 -> out_dest=0x1004, mispredict=0, link_en=1, link_tag=3, link_data=0x204.
  - BLT with x=0xFFFFFFFF, y=1 -> taken; BLTU with the same operands -> not taken.
- **Wakeup and order:** fill DEPTH entries with the head tagx=5 and the rest ready -> no out_en. CDB tag 5 data 7 -> head resolves the following cycle, then one resolution per cycle in order, count counts down to 0.
  - The same-cycle alloc/CDB bypass captures the data.
- **Full/wrap:**
  - At count=DEPTH, alloc is ignored (count stays DEPTH).
  - Simultaneous alloc and issue when not full keeps count constant.
  - Run 3*DEPTH entries through to exercise pointer wrap, with results matching a reference model.
- **Flush/rdy:**
  - Flush with 3 entries queued and the head ready -> no out_en and count=0; subsequent enqueues work.
  - Drop rdy for 3 cycles during a pending issue -> state frozen; the issue occurs after rdy returns.

Source files
------------

// File: rtl/ex_branch_rs.sv
// ex_branch_rs: branch/jump execution unit with an in-order reservation queue.
// Entries wait for both source tags to be resolved by CDB broadcasts. Only the
// head entry issues. On issue the target is computed, compared against the
// predicted next PC, and JAL/JALR link values are presented for the CDB.
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   rdy                   global enable; low freezes all state and outputs
//   flush                 discard every queued entry
//   alloc_*               enqueue request and entry fields
//   cdb_en/tag/data       CDB broadcast used for operand wakeup
//   full, count           queue occupancy
//   out_en, out_dest,
//   out_mispredict        one-cycle resolution result
//   out_link_en/tag/data  link value write for JAL/JALR with rd_tag != 0
module ex_branch_rs #(
   parameter int XLEN  = 32,
   parameter int DEPTH = 4,
   parameter int TAG_W = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     rdy,
   input  logic                     flush,
   input  logic                     alloc_en,
   input  logic [2:0]               alloc_op,
   input  logic [XLEN-1:0]          alloc_pc,
   input  logic [XLEN-1:0]          alloc_offset,
   input  logic [XLEN-1:0]          alloc_pred,
   input  logic [TAG_W-1:0]         alloc_tagx,
   input  logic [TAG_W-1:0]         alloc_tagy,
   input  logic [XLEN-1:0]          alloc_datax,
   input  logic [XLEN-1:0]          alloc_datay,
   input  logic [TAG_W-1:0]         alloc_rd_tag,
   input  logic                     cdb_en,
   input  logic [TAG_W-1:0]         cdb_tag,
   input  logic [XLEN-1:0]          cdb_data,
   output logic                     full,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     out_en,
   output logic [XLEN-1:0]          out_dest,
   output logic                     out_mispredict,
   output logic                     out_link_en,
   output logic [TAG_W-1:0]         out_link_tag,
   output logic [XLEN-1:0]          out_link_data
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [DEPTH-1:0] valid_q, valid_d;
   logic [2:0]       op_q [DEPTH];
   logic [2:0]       op_d [DEPTH];
   logic [XLEN-1:0]  pc_q [DEPTH];
   logic [XLEN-1:0]  pc_d [DEPTH];
   logic [XLEN-1:0]  off_q [DEPTH];
   logic [XLEN-1:0]  off_d [DEPTH];
   logic [XLEN-1:0]  pred_q [DEPTH];
   logic [XLEN-1:0]  pred_d [DEPTH];
   logic [TAG_W-1:0] tagx_q [DEPTH];
   logic [TAG_W-1:0] tagx_d [DEPTH];
   logic [TAG_W-1:0] tagy_q [DEPTH];
   logic [TAG_W-1:0] tagy_d [DEPTH];
   logic [XLEN-1:0]  datax_q [DEPTH];
   logic [XLEN-1:0]  datax_d [DEPTH];
   logic [XLEN-1:0]  datay_q [DEPTH];
   logic [XLEN-1:0]  datay_d [DEPTH];
   logic [TAG_W-1:0] rd_q [DEPTH];
   logic [TAG_W-1:0] rd_d [DEPTH];

   logic             out_en_q, out_en_d;
   logic [XLEN-1:0]  out_dest_q, out_dest_d;
   logic             out_mispredict_q, out_mispredict_d;
   logic             out_link_en_q, out_link_en_d;
   logic [TAG_W-1:0] out_link_tag_q, out_link_tag_d;
   logic [XLEN-1:0]  out_link_data_q, out_link_data_d;

   logic             issue, enq, cdb_hit;
   logic [XLEN-1:0]  res_jump, res_remain, res_jalr_sum, res_dest;
   logic [XLEN-1:0]  hx, hy;
   logic             res_taken, res_link_en;

   assign full  = (count_q == CNT_W'(DEPTH));
   assign count = count_q;
   assign issue = (count_q != '0) && (tagx_q[head_q] == '0) && (tagy_q[head_q] == '0);
   assign enq   = alloc_en && !full;
   // Tag 0 means "already valid", so a broadcast of tag 0 must never match.
   assign cdb_hit = cdb_en && (cdb_tag != '0);

   // Resolution of the head entry; only consumed when it issues.
   always_comb begin
      hx           = datax_q[head_q];
      hy           = datay_q[head_q];
      res_jump     = pc_q[head_q] + off_q[head_q];
      res_remain   = pc_q[head_q] + XLEN'(4);
      res_jalr_sum = hx + off_q[head_q];
      res_taken    = 1'b0;
      res_link_en  = 1'b0;
      res_dest     = res_remain;
      case (op_q[head_q])
         3'd0: res_taken = (hx == hy);
         3'd1: res_taken = (hx != hy);
         3'd2: res_taken = ($signed(hx) <  $signed(hy));
         3'd3: res_taken = ($signed(hx) >= $signed(hy));
         3'd4: res_taken = (hx <  hy);
         3'd5: res_taken = (hx >= hy);
         default: res_taken = 1'b0;
      endcase
      if (op_q[head_q] == 3'd6) begin
         res_dest    = res_jump;
         res_link_en = (rd_q[head_q] != '0);
      end else if (op_q[head_q] == 3'd7) begin
         res_dest    = {res_jalr_sum[XLEN-1:1], 1'b0};
         res_link_en = (rd_q[head_q] != '0);
      end else if (res_taken) begin
         res_dest    = res_jump;
      end
   end

   always_comb begin
      head_d           = head_q;
      tail_d           = tail_q;
      count_d          = count_q;
      valid_d          = valid_q;
      op_d             = op_q;
      pc_d             = pc_q;
      off_d            = off_q;
      pred_d           = pred_q;
      tagx_d           = tagx_q;
      tagy_d           = tagy_q;
      datax_d          = datax_q;
      datay_d          = datay_q;
      rd_d             = rd_q;
      out_en_d         = out_en_q;
      out_dest_d       = out_dest_q;
      out_mispredict_d = out_mispredict_q;
      out_link_en_d    = out_link_en_q;
      out_link_tag_d   = out_link_tag_q;
      out_link_data_d  = out_link_data_q;
      if (rdy) begin
         out_en_d         = 1'b0;
         out_dest_d       = '0;
         out_mispredict_d = 1'b0;
         out_link_en_d    = 1'b0;
         out_link_tag_d   = '0;
         out_link_data_d  = '0;
         if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
            valid_d = '0;
         end else begin
            for (int i = 0; i < DEPTH; i++) begin
               if (valid_q[i] && cdb_hit && (tagx_q[i] == cdb_tag)) begin
                  tagx_d[i]  = '0;
                  datax_d[i] = cdb_data;
               end
               if (valid_q[i] && cdb_hit && (tagy_q[i] == cdb_tag)) begin
                  tagy_d[i]  = '0;
                  datay_d[i] = cdb_data;
               end
            end
            if (issue) begin
               valid_d[head_q]  = 1'b0;
               head_d           = head_q + PTR_W'(1);
               out_en_d         = 1'b1;
               out_dest_d       = res_dest;
               out_mispredict_d = (res_dest != pred_q[head_q]);
               out_link_en_d    = res_link_en;
               if (op_q[head_q] >= 3'd6) begin
                  out_link_tag_d  = rd_q[head_q];
                  out_link_data_d = res_remain;
               end
            end
            // Not full implies tail never aliases the issuing head here.
            if (enq) begin
               valid_d[tail_q] = 1'b1;
               op_d[tail_q]    = alloc_op;
               pc_d[tail_q]    = alloc_pc;
               off_d[tail_q]   = alloc_offset;
               pred_d[tail_q]  = alloc_pred;
               rd_d[tail_q]    = alloc_rd_tag;
               tagx_d[tail_q]  = alloc_tagx;
               datax_d[tail_q] = alloc_datax;
               tagy_d[tail_q]  = alloc_tagy;
               datay_d[tail_q] = alloc_datay;
               if (cdb_hit && (alloc_tagx == cdb_tag)) begin
                  tagx_d[tail_q]  = '0;
                  datax_d[tail_q] = cdb_data;
               end
               if (cdb_hit && (alloc_tagy == cdb_tag)) begin
                  tagy_d[tail_q]  = '0;
                  datay_d[tail_q] = cdb_data;
               end
               tail_d = tail_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(enq) - CNT_W'(issue);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head_q           <= '0;
         tail_q           <= '0;
         count_q          <= '0;
         valid_q          <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            op_q[i]    <= '0;
            pc_q[i]    <= '0;
            off_q[i]   <= '0;
            pred_q[i]  <= '0;
            tagx_q[i]  <= '0;
            tagy_q[i]  <= '0;
            datax_q[i] <= '0;
            datay_q[i] <= '0;
            rd_q[i]    <= '0;
         end
         out_en_q         <= 1'b0;
         out_dest_q       <= '0;
         out_mispredict_q <= 1'b0;
         out_link_en_q    <= 1'b0;
         out_link_tag_q   <= '0;
         out_link_data_q  <= '0;
      end else begin
         head_q           <= head_d;
         tail_q           <= tail_d;
         count_q          <= count_d;
         valid_q          <= valid_d;
         op_q             <= op_d;
         pc_q             <= pc_d;
         off_q            <= off_d;
         pred_q           <= pred_d;
         tagx_q           <= tagx_d;
         tagy_q           <= tagy_d;
         datax_q          <= datax_d;
         datay_q          <= datay_d;
         rd_q             <= rd_d;
         out_en_q         <= out_en_d;
         out_dest_q       <= out_dest_d;
         out_mispredict_q <= out_mispredict_d;
         out_link_en_q    <= out_link_en_d;
         out_link_tag_q   <= out_link_tag_d;
         out_link_data_q  <= out_link_data_d;
      end
   end

   assign out_en         = out_en_q;
   assign out_dest       = out_dest_q;
   assign out_mispredict = out_mispredict_q;
   assign out_link_en    = out_link_en_q;
   assign out_link_tag   = out_link_tag_q;
   assign out_link_data  = out_link_data_q;

endmodule

// File: tb/tb_ex_branch_rs.sv
module tb_ex_branch_rs;

   localparam int XLEN  = 32;
   localparam int DEPTH = 4;
   localparam int TAG_W = 4;

   logic             clk = 1'b0;
   logic             rst, rdy, flush, alloc_en, cdb_en;
   logic [2:0]       alloc_op;
   logic [31:0]      alloc_pc, alloc_offset, alloc_pred, alloc_datax, alloc_datay, cdb_data;
   logic [3:0]       alloc_tagx, alloc_tagy, alloc_rd_tag, cdb_tag;
   logic             full, out_en, out_mispredict, out_link_en;
   logic [2:0]       count;
   logic [31:0]      out_dest, out_link_data;
   logic [3:0]       out_link_tag;

   ex_branch_rs #(.XLEN(XLEN), .DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
      .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
      .alloc_en(alloc_en), .alloc_op(alloc_op), .alloc_pc(alloc_pc),
      .alloc_offset(alloc_offset), .alloc_pred(alloc_pred),
      .alloc_tagx(alloc_tagx), .alloc_tagy(alloc_tagy),
      .alloc_datax(alloc_datax), .alloc_datay(alloc_datay),
      .alloc_rd_tag(alloc_rd_tag), .cdb_en(cdb_en), .cdb_tag(cdb_tag),
      .cdb_data(cdb_data), .full(full), .count(count), .out_en(out_en),
      .out_dest(out_dest), .out_mispredict(out_mispredict),
      .out_link_en(out_link_en), .out_link_tag(out_link_tag),
      .out_link_data(out_link_data)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]  op;
      logic [31:0] pc, off, pred, dx, dy;
      logic [3:0]  tx, ty, rd;
   } ent_t;

   ent_t        mq[$];
   logic        e_en, e_misp, e_len;
   logic [31:0] e_dest, e_ldata;
   logic [3:0]  e_ltag;
   int          checks = 0;
   int          errors = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic void zero_exp();
      e_en = 0; e_misp = 0; e_len = 0; e_dest = 0; e_ltag = 0; e_ldata = 0;
   endfunction

   // Outcome of an instruction straight from the ISA rules.
   function automatic void resolve(input ent_t e);
      logic [31:0] jump, remain;
      logic        take;
      jump   = e.pc + e.off;
      remain = e.pc + 32'd4;
      take   = 0;
      e_len  = 0;
      e_ltag = 0;
      e_ldata = 0;
      case (e.op)
         0: take = e.dx == e.dy;
         1: take = e.dx != e.dy;
         2: take = (e.dx ^ 32'h8000_0000) <  (e.dy ^ 32'h8000_0000);
         3: take = (e.dx ^ 32'h8000_0000) >= (e.dy ^ 32'h8000_0000);
         4: take = e.dx <  e.dy;
         5: take = e.dx >= e.dy;
         default: take = 0;
      endcase
      if (e.op == 6) e_dest = jump;
      else if (e.op == 7) e_dest = (e.dx + e.off) & 32'hFFFF_FFFE;
      else e_dest = take ? jump : remain;
      if (e.op >= 6) begin
         e_len   = e.rd != 0;
         e_ltag  = e.rd;
         e_ldata = remain;
      end
      e_en   = 1;
      e_misp = e_dest != e.pred;
   endfunction

   // Advances the reference queue by one clock edge using current inputs.
   function automatic void model_edge();
      bit   was_full, iss;
      ent_t e;
      if (!rdy) return;
      if (flush) begin
         mq.delete();
         zero_exp();
         return;
      end
      was_full = mq.size() == DEPTH;
      iss = mq.size() > 0 && mq[0].tx == 0 && mq[0].ty == 0;
      if (iss) resolve(mq[0]);
      else zero_exp();
      if (cdb_en && cdb_tag != 0) begin
         foreach (mq[i]) begin
            if (mq[i].tx == cdb_tag) begin mq[i].tx = 0; mq[i].dx = cdb_data; end
            if (mq[i].ty == cdb_tag) begin mq[i].ty = 0; mq[i].dy = cdb_data; end
         end
      end
      if (iss) void'(mq.pop_front());
      if (alloc_en && !was_full) begin
         e.op = alloc_op; e.pc = alloc_pc; e.off = alloc_offset; e.pred = alloc_pred;
         e.tx = alloc_tagx; e.ty = alloc_tagy; e.dx = alloc_datax; e.dy = alloc_datay;
         e.rd = alloc_rd_tag;
         if (cdb_en && cdb_tag != 0 && e.tx == cdb_tag) begin e.tx = 0; e.dx = cdb_data; end
         if (cdb_en && cdb_tag != 0 && e.ty == cdb_tag) begin e.ty = 0; e.dy = cdb_data; end
         mq.push_back(e);
      end
   endfunction

   task automatic compare_all();
      chk("count", 32'(count), 32'(mq.size()));
      chk("full", 32'(full), 32'(mq.size() == DEPTH));
      chk("out_en", 32'(out_en), 32'(e_en));
      chk("out_mispredict", 32'(out_mispredict), 32'(e_misp));
      chk("out_link_en", 32'(out_link_en), 32'(e_len));
      if (e_en) chk("out_dest", out_dest, e_dest);
      if (e_len) begin
         chk("out_link_tag", 32'(out_link_tag), 32'(e_ltag));
         chk("out_link_data", out_link_data, e_ldata);
      end
      if (!e_en) begin
         chk("idle_dest", out_dest, 0);
         chk("idle_link_tag", 32'(out_link_tag), 0);
         chk("idle_link_data", out_link_data, 0);
      end
   endtask

   task automatic step();
      model_edge();
      @(posedge clk);
      #1;
      compare_all();
   endtask

   task automatic idle_in();
      flush = 0; alloc_en = 0; cdb_en = 0; cdb_tag = 0; cdb_data = 0;
      alloc_op = 0; alloc_pc = 0; alloc_offset = 0; alloc_pred = 0;
      alloc_tagx = 0; alloc_tagy = 0; alloc_datax = 0; alloc_datay = 0; alloc_rd_tag = 0;
   endtask

   task automatic set_alloc(input logic [2:0] op, input logic [31:0] pc, off, pred,
                            input logic [3:0] tx, ty, input logic [31:0] dx, dy,
                            input logic [3:0] rd);
      alloc_en = 1; alloc_op = op; alloc_pc = pc; alloc_offset = off; alloc_pred = pred;
      alloc_tagx = tx; alloc_tagy = ty; alloc_datax = dx; alloc_datay = dy; alloc_rd_tag = rd;
   endtask

   initial begin
      rst = 1; rdy = 1;
      idle_in();
      zero_exp();
      repeat (2) @(posedge clk);
      #1;
      compare_all();
      rst = 0;

      // Taken BEQ
      set_alloc(0, 32'h100, 32'h20, 32'h104, 0, 0, 5, 5, 0);
      step();
      idle_in();
      step();
      chk("beq_en", 32'(out_en), 1);
      chk("beq_dest", out_dest, 32'h120);
      chk("beq_misp", 32'(out_mispredict), 1);
      chk("beq_link_en", 32'(out_link_en), 0);

      // Asynchronous reset mid-cycle while a result is showing
      #3 rst = 1;
      #1;
      mq.delete();
      zero_exp();
      chk("rst_out_en", 32'(out_en), 0);
      chk("rst_dest", out_dest, 0);
      chk("rst_misp", 32'(out_mispredict), 0);
      chk("rst_count", 32'(count), 0);
      chk("rst_full", 32'(full), 0);
      @(negedge clk);
      rst = 0;

      // JALR with link
      set_alloc(7, 32'h200, 32'h4, 32'h1004, 0, 0, 32'h1001, 0, 3);
      step();
      idle_in();
      step();
      chk("jalr_dest", out_dest, 32'h1004);
      chk("jalr_misp", 32'(out_mispredict), 0);
      chk("jalr_link_en", 32'(out_link_en), 1);
      chk("jalr_link_tag", 32'(out_link_tag), 3);
      chk("jalr_link_data", out_link_data, 32'h204);

      // BLT signed taken, then BLTU unsigned not taken; alloc+issue keeps count
      set_alloc(2, 32'h300, 32'h40, 32'h304, 0, 0, 32'hFFFF_FFFF, 1, 0);
      step();
      set_alloc(4, 32'h300, 32'h40, 32'h304, 0, 0, 32'hFFFF_FFFF, 1, 0);
      step();
      chk("blt_dest", out_dest, 32'h340);
      chk("alloc_issue_count", 32'(count), 1);
      idle_in();
      step();
      chk("bltu_dest", out_dest, 32'h304);
      chk("bltu_misp", 32'(out_mispredict), 0);

      // Wakeup and ordering: unready head blocks three ready entries
      set_alloc(0, 32'h400, 32'h10, 32'h404, 5, 0, 0, 7, 0);
      step();
      for (int i = 0; i < 3; i++) begin
         set_alloc(6, 32'h500 + 32'(4 * i), 32'h100, 32'h600 + 32'(4 * i), 0, 0, 0, 0, 4'(i + 1));
         step();
      end
      chk("fill_count", 32'(count), 4);
      chk("fill_full", 32'(full), 1);
      set_alloc(6, 32'h900, 0, 0, 0, 0, 0, 0, 1);
      step();
      chk("full_ignore_count", 32'(count), 4);
      chk("blocked_out_en", 32'(out_en), 0);
      idle_in();
      cdb_en = 1; cdb_tag = 5; cdb_data = 7;
      step();
      chk("wake_edge_out_en", 32'(out_en), 0);
      idle_in();
      step();
      chk("woken_dest", out_dest, 32'h410);
      chk("woken_count", 32'(count), 3);
      for (int i = 0; i < 3; i++) begin
         step();
         chk("order_dest", out_dest, 32'h600 + 32'(4 * i));
         chk("order_count", 32'(count), 32'(2 - i));
      end

      // Same-cycle alloc/CDB bypass
      set_alloc(1, 32'h700, 32'h40, 32'h704, 6, 0, 0, 9, 0);
      cdb_en = 1; cdb_tag = 6; cdb_data = 9;
      step();
      idle_in();
      step();
      chk("bypass_en", 32'(out_en), 1);
      chk("bypass_dest", out_dest, 32'h704);

      // Flush with ready head suppresses the pending issue
      set_alloc(0, 32'h800, 32'h10, 0, 8, 0, 0, 0, 0);
      step();
      set_alloc(6, 32'h810, 32'h10, 0, 0, 0, 0, 0, 1);
      step();
      set_alloc(6, 32'h820, 32'h10, 0, 0, 0, 0, 0, 1);
      step();
      idle_in();
      cdb_en = 1; cdb_tag = 8; cdb_data = 1;
      step();
      idle_in();
      flush = 1;
      step();
      chk("flush_out_en", 32'(out_en), 0);
      chk("flush_count", 32'(count), 0);
      idle_in();
      set_alloc(6, 32'h900, 32'h8, 32'h908, 0, 0, 0, 0, 2);
      step();
      idle_in();
      step();
      chk("post_flush_dest", out_dest, 32'h908);
      chk("post_flush_link", out_link_data, 32'h904);

      // rdy low freezes a pending issue
      set_alloc(6, 32'hA00, 32'h10, 32'hA10, 0, 0, 0, 0, 0);
      step();
      idle_in();
      rdy = 0;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("frozen_out_en", 32'(out_en), 0);
         chk("frozen_count", 32'(count), 1);
      end
      rdy = 1;
      step();
      chk("thaw_dest", out_dest, 32'hA10);
      chk("thaw_count", 32'(count), 0);

      // Randomized traffic with pointer wrap, full, flush and rdy gaps
      for (int n = 0; n < 400; n++) begin
         logic [31:0] pc, off;
         idle_in();
         rdy = ($urandom_range(0, 9) != 0);
         flush = ($urandom_range(0, 39) == 0);
         pc  = $urandom & 32'hFFFF_FFFC;
         off = ($urandom_range(0, 1) != 0) ? 32'($urandom_range(0, 255)) : $urandom;
         if ($urandom_range(0, 2) != 0) begin
            set_alloc(3'($urandom_range(0, 7)), pc, off, 32'h0,
                      ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 3)) : 4'd0,
                      ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 3)) : 4'd0,
                      ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 3)),
                      ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 3)),
                      4'($urandom_range(0, 3)));
            case ($urandom_range(0, 2))
               0: alloc_pred = pc + 32'd4;
               1: alloc_pred = pc + off;
               default: alloc_pred = $urandom;
            endcase
         end
         if ($urandom_range(0, 1) != 0) begin
            cdb_en = 1;
            cdb_tag = 4'($urandom_range(0, 3));
            cdb_data = ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 3));
         end
         step();
      end

      idle_in();
      rdy = 1;
      repeat (DEPTH + 1) step();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
